// File: rtl/lsu.sv
// RV32I load/store unit: single-outstanding req/gnt/rvalid memory port, lane steering and load extension.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects misaligned H/W accesses instead of forcing alignment.
module lsu #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_ld_valid,
  output logic [31:0]       o_ld_data,
  output logic              o_st_done,
  output logic              o_misaligned
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              reject;
  logic              accept;
  logic              done_st;
  logic              done_ld;
  logic [BE_W-1:0]   be_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] ld_d;
  logic [DATA_W-1:0] rdata_b;
  logic [DATA_W-1:0] rdata_h;
  logic              ld_sign;

`ifdef LSU_MISALIGN_CHECK_EN
  // Halfword on an odd byte, or word off a word boundary, never reaches memory.
  assign reject = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                  (i_funct3[1] && (i_addr[1:0] != 2'b00));
`else
  assign reject = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && i_req && !reject;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a load granted with rvalid in the same cycle skips WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        if (i_mem_gnt) begin
          if (o_mem_we || i_mem_rvalid) state_d = S_IDLE;
          else                          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: lane steering on accept, extraction on completion.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = i_wdata;
    ld_d    = i_mem_rdata;
    done_st = 1'b0;
    done_ld = 1'b0;
    ld_sign = ~funct3_q[2];
    rdata_b = i_mem_rdata >> {off_q, 3'b000};
    rdata_h = i_mem_rdata >> {off_q[1], 4'b0000};

    unique case (i_funct3[1:0])
      2'b00: begin
        be_d    = 4'(4'b0001 << i_addr[1:0]);
        wdata_d = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{i_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = i_wdata;
      end
    endcase

    unique case (funct3_q[1:0])
      2'b00:   ld_d = {{24{ld_sign & rdata_b[7]}}, rdata_b[7:0]};
      2'b01:   ld_d = {{16{ld_sign & rdata_h[15]}}, rdata_h[15:0]};
      default: ld_d = i_mem_rdata;
    endcase

    if (state_q == S_REQ && i_mem_gnt) begin
      done_st = o_mem_we;
      done_ld = !o_mem_we && i_mem_rvalid;
    end else if (state_q == S_WAIT) begin
      done_ld = i_mem_rvalid;
    end
  end

  // Registered outputs and captured request fields.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready     <= 1'b1;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
      o_ld_valid  <= 1'b0;
      o_ld_data   <= '0;
      o_st_done   <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
    end else begin
      o_ready    <= (state_d == S_IDLE);
      o_mem_req  <= (state_d == S_REQ);
      o_ld_valid <= done_ld;
      o_st_done  <= done_st;
      if (done_ld) o_ld_data <= ld_d;
      if (accept) begin
        o_mem_we    <= i_we;
        o_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
        o_mem_be    <= be_d;
        o_mem_wdata <= wdata_d;
        funct3_q    <= i_funct3;
        off_q       <= i_addr[1:0];
      end
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_misaligned <= 1'b0;
    end else begin
      o_misaligned <= (state_q == S_IDLE) && i_req && reject;
    end
  end
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, multi-cycle corner sequences, randomized ops vs. a byte-level model.
module tb_lsu;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_req;
  logic          o_ready;
  logic          i_we;
  logic [2:0]    i_funct3;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_wdata;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_be;
  logic [31:0]   o_mem_wdata;
  logic          i_mem_gnt;
  logic          i_mem_rvalid;
  logic [31:0]   i_mem_rdata;
  logic          o_ld_valid;
  logic [31:0]   o_ld_data;
  logic          o_st_done;
  logic          o_misaligned;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_ready(o_ready),
    .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_ld_valid(o_ld_valid), .o_ld_data(o_ld_data), .o_st_done(o_st_done),
    .o_misaligned(o_misaligned)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: access size and start byte straight from the RV32I rules.
  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int m_start(input logic [2:0] f3, input logic [31:0] addr);
    int sz = m_size(f3);
    int lo = int'(addr % 4);
    return lo - (lo % sz);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be = '0;
    int st = m_start(f3, addr);
    int sz = m_size(f3);
    for (int b = 0; b < 4; b++) be[b] = (b >= st) && (b < st + sz);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz = m_size(f3);
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v = '0;
    int st = m_start(f3, addr);
    int sz = m_size(f3);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(st+i) +: 8];
    if (sz < 4 && f3[2] == 1'b0 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  // One complete memory operation with configurable grant / response delay.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int gdly, input int rdly, input bit stray,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_ld);
    logic [31:0] exp_addr = {addr[31:2], 2'b00};
    tick();
    chk1("ready_idle", o_ready, 1'b1);
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    tick();
    i_req = 1'b0; i_addr = $urandom; i_wdata = $urandom; i_funct3 = 3'($urandom);
    chk1("mem_req", o_mem_req, 1'b1);
    chk1("mem_we", o_mem_we, we);
    chk32("mem_addr", o_mem_addr, exp_addr);
    chk32("mem_be", 32'(o_mem_be), 32'(exp_be));
    if (we) chk32("mem_wdata", o_mem_wdata, exp_wd);
    chk1("ready_busy", o_ready, 1'b0);
    chk1("misaligned_quiet", o_misaligned, 1'b0);
    for (int g = 0; g < gdly; g++) begin
      i_mem_gnt = 1'b0;
      if (stray) begin
        i_req = 1'b1; i_we = ~we;
        i_mem_rvalid = 1'($urandom_range(0, 1)); i_mem_rdata = ~rdata;
      end
      tick();
      i_req = 1'b0; i_mem_rvalid = 1'b0;
      chk1("stall_req", o_mem_req, 1'b1);
      chk32("stall_addr", o_mem_addr, exp_addr);
      chk32("stall_be", 32'(o_mem_be), 32'(exp_be));
      chk1("stall_ready", o_ready, 1'b0);
      chk1("stall_no_ld", o_ld_valid, 1'b0);
    end
    i_mem_gnt = 1'b1;
    i_mem_rvalid = !we && rdly == 0;
    i_mem_rdata = rdata;
    tick();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    if (we) begin
      chk1("st_done", o_st_done, 1'b1);
      chk1("st_ready", o_ready, 1'b1);
      chk1("st_no_ld", o_ld_valid, 1'b0);
    end else if (rdly == 0) begin
      chk1("ld_valid_0w", o_ld_valid, 1'b1);
      chk32("ld_data_0w", o_ld_data, exp_ld);
    end else begin
      chk1("wait_no_req", o_mem_req, 1'b0);
      chk1("wait_ready", o_ready, 1'b0);
      for (int r = 1; r < rdly; r++) begin
        chk1("wait_no_ld", o_ld_valid, 1'b0);
        tick();
      end
      i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
      tick();
      i_mem_rvalid = 1'b0; i_mem_rdata = $urandom;
      chk1("ld_valid", o_ld_valid, 1'b1);
      chk32("ld_data", o_ld_data, exp_ld);
      chk1("ld_ready", o_ready, 1'b1);
    end
    tick();
    chk1("ld_pulse_end", o_ld_valid, 1'b0);
    chk1("st_pulse_end", o_st_done, 1'b0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp_wd;
    logic [31:0] exp_ld;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

    vecs[0] = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[2] = '{1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 4'b1100, 32'h1234_1234, 32'h0};
    vecs[3] = '{1'b0, 3'b000, 32'h0000_0202, 32'h0, 32'h80FF_7F01, 4'b0100, 32'h0, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 4'b1000, 32'h0, 32'h0000_0080};
    vecs[5] = '{1'b0, 3'b001, 32'h0000_0200, 32'h0, 32'h80FF_7F01, 4'b0011, 32'h0, 32'h0000_7F01};
    vecs[6] = '{1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h80FF_7F01, 4'b1100, 32'h0, 32'h0000_80FF};
    vecs[7] = '{1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0, 4'b1111, 32'h0BAD_F00D, 32'h0};

    tick(); tick();
    chk1("rst_ready", o_ready, 1'b1);
    chk1("rst_mem_req", o_mem_req, 1'b0);
    chk32("rst_mem_addr", o_mem_addr, 32'h0);
    chk1("rst_ld_valid", o_ld_valid, 1'b0);
    chk1("rst_st_done", o_st_done, 1'b0);
    chk1("rst_misaligned", o_misaligned, 1'b0);
    i_rst_n = 1'b1;
    tick();

    // Directed table, zero-wait memory.
    for (int i = 0; i < NV; i++)
      run_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 0, 0, 1'b0,
             vecs[i].be, vecs[i].exp_wd, vecs[i].exp_ld);

    // Grant held off 3 cycles, response 2 cycles after grant, stray requests ignored.
    run_op(1'b0, 3'b000, 32'h0000_0301, 32'h0, 32'h80FF_7F01, 3, 2, 1'b1,
           4'b0010, 32'h0, 32'h0000_007F);
    run_op(1'b1, 3'b001, 32'h0000_0400, 32'h0000_CAFE, 32'h0, 3, 0, 1'b1,
           4'b0011, 32'hCAFE_CAFE, 32'h0);

    // Reset while waiting for read data; a late rvalid must be ignored.
    tick();
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0500;
    tick();
    i_req = 1'b0; i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    chk1("rstmid_in_wait", o_mem_req, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk1("rstmid_ready_async", o_ready, 1'b1);
    tick();
    i_rst_n = 1'b1;
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678;
    tick();
    i_mem_rvalid = 1'b0;
    chk1("rstmid_no_ld", o_ld_valid, 1'b0);
    chk1("rstmid_ready", o_ready, 1'b1);
    chk1("rstmid_mem_req", o_mem_req, 1'b0);
    chk32("rstmid_ld_data", o_ld_data, 32'h0);
    chk32("rstmid_mem_addr", o_mem_addr, 32'h0);
    chk32("rstmid_mem_be", 32'(o_mem_be), 32'h0);
    chk32("rstmid_mem_wdata", o_mem_wdata, 32'h0);
    tick();
    chk1("rstmid_no_ld_later", o_ld_valid, 1'b0);

`ifdef LSU_MISALIGN_CHECK_EN
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0102;
    tick();
    i_req = 1'b0;
    chk1("mis_pulse", o_misaligned, 1'b1);
    chk1("mis_no_req", o_mem_req, 1'b0);
    chk1("mis_ready", o_ready, 1'b1);
    tick();
    chk1("mis_pulse_end", o_misaligned, 1'b0);
    chk1("mis_still_no_req", o_mem_req, 1'b0);
`else
    run_op(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 0, 0, 1'b0,
           4'b1111, 32'h0, 32'h80FF_7F01);
`endif

    // Randomized operations against the byte-level model.
    for (int n = 0; n < 60; n++) begin
      logic        we = 1'($urandom_range(0, 1));
      logic [2:0]  f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      logic [31:0] addr = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rd = $urandom;
`ifdef LSU_MISALIGN_CHECK_EN
      addr = addr & ~32'(m_size(f3) - 1);
`endif
      run_op(we, f3, addr, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), m_be(f3, addr), m_wdata(f3, wd), m_load(f3, addr, rd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
